// File: rtl/fight_control.sv
// Turn-based fight scene controller: option menu, attack animations
// and tick-paced HP reduction for two players.
module fight_control #(
    parameter int MAX_HP     = 200,
    parameter int ANIM_TICKS = 30,
    parameter int P2_DMG     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    output logic [5:0] fight_state,
    output logic [3:0] option_state,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic [1:0] winner,
    output logic       fight_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MENU     = 3'd1,
        CHOOSE   = 3'd2,
        ANIM_P1  = 3'd3,
        ANIM_P2  = 3'd4,
        HPRED_P1 = 3'd5,
        HPRED_P2 = 3'd6,
        END      = 3'd7
    } state_t;

    localparam int CW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(ANIM_TICKS - 1);
    localparam logic [7:0] HP_FULL = 8'(MAX_HP);
    localparam logic [7:0] P2_HIT = 8'(P2_DMG);

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [7:0]    skill_dmg;
    logic [7:0]    rem_dmg;

    // Grid move for one navigation key; moves off the grid are dropped.
    function automatic logic [3:0] nav(
        input logic [3:0] o,
        input logic       up,
        input logic       down,
        input logic       left,
        input logic       right
    );
        nav = o;
        if (up) begin
            if (o == 4'd3) nav = 4'd1;
            else if (o == 4'd4) nav = 4'd2;
        end else if (down) begin
            if (o == 4'd1) nav = 4'd3;
            else if (o == 4'd2) nav = 4'd4;
        end else if (left) begin
            if (o == 4'd2) nav = 4'd1;
            else if (o == 4'd4) nav = 4'd3;
        end else if (right) begin
            if (o == 4'd1) nav = 4'd2;
            else if (o == 4'd3) nav = 4'd4;
        end
    endfunction

    // Skill damage is ten points per grid position.
    function automatic logic [7:0] dmg_of(input logic [3:0] o);
        case (o)
            4'd1:    dmg_of = 8'd10;
            4'd2:    dmg_of = 8'd20;
            4'd3:    dmg_of = 8'd30;
            4'd4:    dmg_of = 8'd40;
            default: dmg_of = 8'd0;
        endcase
    endfunction

    // The state register itself is the registered scene code.
    assign fight_state = {3'b000, state};

    // Fight sequencer; all outputs are flops updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            option_state <= 4'd0;
            p1_cur_hp    <= 8'd0;
            p2_cur_hp    <= 8'd0;
            winner       <= 2'd0;
            fight_done   <= 1'b0;
            tick_cnt     <= '0;
            skill_dmg    <= 8'd0;
            rem_dmg      <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        p1_cur_hp    <= HP_FULL;
                        p2_cur_hp    <= HP_FULL;
                        winner       <= 2'd0;
                        option_state <= 4'd1;
                        state        <= MENU;
                    end
                end
                MENU: begin
                    if (key_enter) begin
                        if (option_state == 4'd1) state <= CHOOSE;
                    end else begin
                        option_state <= nav(option_state, key_up,
                                            key_down, key_left, key_right);
                    end
                end
                CHOOSE: begin
                    if (key_enter) begin
                        skill_dmg    <= dmg_of(option_state);
                        tick_cnt     <= '0;
                        option_state <= 4'd0;
                        state        <= ANIM_P1;
                    end else begin
                        option_state <= nav(option_state, key_up,
                                            key_down, key_left, key_right);
                    end
                end
                ANIM_P1: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            rem_dmg <= skill_dmg;
                            state   <= HPRED_P2;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                ANIM_P2: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            rem_dmg <= P2_HIT;
                            state   <= HPRED_P1;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                HPRED_P2: begin
                    if (tick) begin
                        rem_dmg <= (rem_dmg != 8'd0) ? rem_dmg - 8'd1 : 8'd0;
                        if (p2_cur_hp <= 8'd1) begin
                            p2_cur_hp  <= 8'd0;
                            winner     <= 2'd1;
                            fight_done <= 1'b1;
                            state      <= END;
                        end else begin
                            p2_cur_hp <= p2_cur_hp - 8'd1;
                            if (rem_dmg <= 8'd1) begin
                                tick_cnt <= '0;
                                state    <= ANIM_P2;
                            end
                        end
                    end
                end
                HPRED_P1: begin
                    if (tick) begin
                        rem_dmg <= (rem_dmg != 8'd0) ? rem_dmg - 8'd1 : 8'd0;
                        if (p1_cur_hp <= 8'd1) begin
                            p1_cur_hp  <= 8'd0;
                            winner     <= 2'd2;
                            fight_done <= 1'b1;
                            state      <= END;
                        end else begin
                            p1_cur_hp <= p1_cur_hp - 8'd1;
                            if (rem_dmg <= 8'd1) begin
                                option_state <= 4'd1;
                                state        <= MENU;
                            end
                        end
                    end
                end
                END: begin
                    if (key_enter) begin
                        option_state <= 4'd0;
                        fight_done   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fight_control.sv
// Scoreboard bench for fight_control: a default instance and one
// with MAX_HP=65 to reach the HP=25 knockout boundary.
module tb_fight_control;

    localparam logic [6:0] K_START = 7'b1000000;
    localparam logic [6:0] K_TICK  = 7'b0100000;
    localparam logic [6:0] K_ENTER = 7'b0010000;
    localparam logic [6:0] K_UP    = 7'b0001000;
    localparam logic [6:0] K_DOWN  = 7'b0000100;
    localparam logic [6:0] K_LEFT  = 7'b0000010;
    localparam logic [6:0] K_RIGHT = 7'b0000001;

    typedef struct {
        string      name;
        bit         sel;
        logic [28:0] want;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] in_a = '0;
    logic [6:0] in_b = '0;

    logic [5:0] fs_a, fs_b;
    logic [3:0] op_a, op_b;
    logic [7:0] p1_a, p1_b, p2_a, p2_b;
    logic [1:0] w_a, w_b;
    logic       d_a, d_b;

    exp_t sb[$];
    exp_t e;
    logic [28:0] got;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fight_control u_a (
        .clk(clk), .rst_n(rst_n), .tick(in_a[5]), .start(in_a[6]),
        .key_up(in_a[3]), .key_down(in_a[2]), .key_left(in_a[1]),
        .key_right(in_a[0]), .key_enter(in_a[4]),
        .fight_state(fs_a), .option_state(op_a), .p1_cur_hp(p1_a),
        .p2_cur_hp(p2_a), .winner(w_a), .fight_done(d_a)
    );

    fight_control #(.MAX_HP(65)) u_b (
        .clk(clk), .rst_n(rst_n), .tick(in_b[5]), .start(in_b[6]),
        .key_up(in_b[3]), .key_down(in_b[2]), .key_left(in_b[1]),
        .key_right(in_b[0]), .key_enter(in_b[4]),
        .fight_state(fs_b), .option_state(op_b), .p1_cur_hp(p1_b),
        .p2_cur_hp(p2_b), .winner(w_b), .fight_done(d_b)
    );

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) got = {fs_b, op_b, p1_b, p2_b, w_b, d_b};
            else       got = {fs_a, op_a, p1_a, p2_a, w_a, d_a};
            checks++;
            if (got !== e.want) begin
                errors++;
                $display("FAIL %s: got st=%0d opt=%0d p1=%0d p2=%0d w=%0d d=%0d want st=%0d opt=%0d p1=%0d p2=%0d w=%0d d=%0d",
                         e.name, got[28:23], got[22:19], got[18:11],
                         got[10:3], got[2:1], got[0],
                         e.want[28:23], e.want[22:19], e.want[18:11],
                         e.want[10:3], e.want[2:1], e.want[0]);
            end
        end
    end

    task automatic drive(input bit sel, input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            in_a = sel ? 7'd0 : v;
            in_b = sel ? v : 7'd0;
            @(posedge clk);
            #1;
            in_a = '0;
            in_b = '0;
        end
    endtask

    task automatic chk(input string name, input bit sel,
                       input int st, input int opt, input int p1,
                       input int p2, input int w, input int d);
        exp_t x;
        x.name = name;
        x.sel  = sel;
        x.want = {6'(st), 4'(opt), 8'(p1), 8'(p2), 2'(w), 1'(d)};
        sb.push_back(x);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_a", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_b", 1, 0, 0, 0, 0, 0, 0);

        drive(0, K_START, 1);           chk("start", 0, 1, 1, 200, 200, 0, 0);
        drive(0, K_START | K_TICK, 1);  chk("menu_start_tick", 0, 1, 1, 200, 200, 0, 0);
        drive(0, K_LEFT, 1);            chk("edge1_left", 0, 1, 1, 200, 200, 0, 0);
        drive(0, K_UP, 1);              chk("edge1_up", 0, 1, 1, 200, 200, 0, 0);
        drive(0, K_RIGHT, 1);           chk("nav_right", 0, 1, 2, 200, 200, 0, 0);
        drive(0, K_DOWN, 1);            chk("nav_down", 0, 1, 4, 200, 200, 0, 0);
        drive(0, K_RIGHT, 1);           chk("edge4_right", 0, 1, 4, 200, 200, 0, 0);
        drive(0, K_DOWN, 1);            chk("edge4_down", 0, 1, 4, 200, 200, 0, 0);
        drive(0, K_UP | K_LEFT, 1);     chk("prio_up_left", 0, 1, 2, 200, 200, 0, 0);
        drive(0, K_ENTER, 1);           chk("enter_opt2", 0, 1, 2, 200, 200, 0, 0);
        drive(0, K_LEFT, 1);            chk("nav_left", 0, 1, 1, 200, 200, 0, 0);
        drive(0, K_ENTER | K_DOWN, 1);  chk("prio_enter", 0, 2, 1, 200, 200, 0, 0);
        drive(0, K_RIGHT, 1);           chk("choose_right", 0, 2, 2, 200, 200, 0, 0);
        drive(0, K_DOWN, 1);            chk("choose_down", 0, 2, 4, 200, 200, 0, 0);
        drive(0, K_ENTER, 1);           chk("anim_p1", 0, 3, 0, 200, 200, 0, 0);
        drive(0, K_ENTER | K_RIGHT, 1); chk("anim_keys", 0, 3, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 29);           chk("anim_29", 0, 3, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 1);            chk("anim_30", 0, 6, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 30);           chk("hpred_170", 0, 6, 0, 200, 170, 0, 0);
        rst_pulse();                    chk("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        drive(0, K_START, 1);           chk("restart", 0, 1, 1, 200, 200, 0, 0);

        drive(0, K_ENTER, 1);
        drive(0, K_RIGHT, 1);
        drive(0, K_DOWN, 1);
        drive(0, K_ENTER, 1);           chk("s4_anim", 0, 3, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 30);           chk("s4_hpred", 0, 6, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 39);           chk("s4_39", 0, 6, 0, 200, 161, 0, 0);
        drive(0, K_TICK, 1);            chk("s4_40", 0, 4, 0, 200, 160, 0, 0);
        drive(0, K_TICK, 30);           chk("p2_anim", 0, 5, 0, 200, 160, 0, 0);
        drive(0, K_TICK, 14);           chk("p1_14", 0, 5, 0, 186, 160, 0, 0);
        drive(0, K_TICK, 1);            chk("round_s4", 0, 1, 1, 185, 160, 0, 0);

        rst_pulse();
        drive(0, K_START, 1);
        drive(0, K_ENTER, 2);           chk("s1_anim", 0, 3, 0, 200, 200, 0, 0);
        drive(0, K_TICK, 40);           chk("s1_hit", 0, 4, 0, 200, 190, 0, 0);
        drive(0, K_TICK, 45);           chk("round_s1", 0, 1, 1, 185, 190, 0, 0);

        drive(1, K_START, 1);           chk("b_start", 1, 1, 1, 65, 65, 0, 0);
        drive(1, K_ENTER, 1);
        drive(1, K_RIGHT, 1);
        drive(1, K_DOWN, 1);
        drive(1, K_ENTER, 1);
        drive(1, K_TICK, 70);           chk("b_hit1", 1, 4, 0, 65, 25, 0, 0);
        drive(1, K_TICK, 45);           chk("b_round", 1, 1, 1, 50, 25, 0, 0);
        drive(1, K_ENTER, 1);
        drive(1, K_RIGHT, 1);
        drive(1, K_DOWN, 1);
        drive(1, K_ENTER, 1);           chk("b_anim", 1, 3, 0, 50, 25, 0, 0);
        drive(1, K_TICK, 54);           chk("b_hp1", 1, 6, 0, 50, 1, 0, 0);
        drive(1, K_TICK, 1);            chk("b_ko", 1, 7, 0, 50, 0, 1, 1);
        drive(1, K_TICK | K_START, 1);  chk("b_end_hold", 1, 7, 0, 50, 0, 1, 1);
        drive(1, K_ENTER, 1);           chk("b_idle", 1, 0, 0, 50, 0, 1, 0);
        drive(1, K_TICK | K_ENTER, 1);  chk("b_idle_hold", 1, 0, 0, 50, 0, 1, 0);
        drive(1, K_START, 1);           chk("b_restart", 1, 1, 1, 65, 65, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fight_control.md
FIGHT_CONTROL -- requirements
Module: fight_control

Interface
REQ-001 SHALL have parameter MAX_HP, default 200, starting HP of both players (must be at most 255).
REQ-002 SHALL have parameter ANIM_TICKS, default 30, number of tick pulses per attack animation.
REQ-003 SHALL have parameter P2_DMG, default 15, fixed damage of the P2 attack.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port tick, input, 1, one-cycle animation-rate enable pulse.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a fight.
REQ-008 SHALL have ports key_up, key_down, key_left, key_right and key_enter, each input, 1, a one-cycle debounced key pulse.
REQ-009 SHALL have port fight_state, output, 6, scene state code consumed by the fight renderer.
REQ-010 SHALL have port option_state, output, 4, highlighted option; 0 = none, 1..4 = the 2x2 option grid.
REQ-011 SHALL have port p1_cur_hp, output, 8, P1 HP; the renderer also uses it as the HP-bar width in pixels.
REQ-012 SHALL have port p2_cur_hp, output, 8, P2 HP, same encoding as p1_cur_hp.
REQ-013 SHALL have port winner, output, 2, fight result: 0 = none, 1 = P1 won, 2 = P2 won.
REQ-014 SHALL have port fight_done, output, 1, high only while in state END.

Function
REQ-015 SHALL use these state codes: IDLE=0, MENU=1, CHOOSE=2, ANIM_P1=3, ANIM_P2=4, HPRED_P1=5 (P1 HP falling), HPRED_P2=6 (P2 HP falling), END=7.
REQ-016 SHALL drive fight_state as a registered copy of the current state code.
REQ-017 SHALL use this option grid: 1 = top-left, 2 = top-right, 3 = bottom-left, 4 = bottom-right.
REQ-018 SHALL, in MENU or CHOOSE, handle navigation keys as follows, with no wrap-around:
- key_left moves to the left column (2->1, 4->3).
- key_right moves to the right column (1->2, 3->4).
- key_up moves to the top row (3->1, 4->2).
- key_down moves to the bottom row (1->3, 2->4).
- A key that would leave the grid SHALL leave option_state unchanged.
REQ-019 SHALL, when several key pulses arrive in one cycle, act on only one, in priority enter > up > down > left > right.
REQ-020 SHALL, in IDLE, on start:
- load both HPs with MAX_HP;
- set winner=0 and option_state=1;
- enter MENU.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL, in MENU, on key_enter with option_state=1, enter CHOOSE with option_state=1; key_enter with options 2..4 SHALL have no effect.
REQ-023 SHALL, in CHOOSE, on key_enter:
- latch skill damage = 10 x option_state (10/20/30/40);
- clear the tick counter;
- enter ANIM_P1 with option_state=0.
REQ-024 SHALL, in ANIM_P1 and ANIM_P2, count tick pulses and leave the state on the cycle of the ANIM_TICKS-th tick:
- ANIM_P1 goes to HPRED_P2, loading remaining damage = skill damage.
- ANIM_P2 goes to HPRED_P1, loading remaining damage = P2_DMG.
REQ-025 SHALL, in HPRED_x, on each tick, decrement both the target HP and the remaining damage by 1.
REQ-026 SHALL leave HPRED_x on the tick where, before the decrement, the target HP = 1 or the remaining damage = 1:
- If the target HP reaches 0, go to END; winner=1 when P2 hits 0, winner=2 when P1 hits 0.
- Otherwise HPRED_P2 goes to ANIM_P2 with the tick counter cleared, and HPRED_P1 goes to MENU with option_state=1.
REQ-027 SHALL never let HP underflow below 0 and never change HP outside the HPRED states.
REQ-028 SHALL, in END, on key_enter, go to IDLE with option_state=0; HP and winner SHALL hold until the next start.
REQ-029 SHALL ignore key pulses in the ANIM, HPRED and IDLE states.
REQ-030 SHALL ignore tick in MENU, CHOOSE, IDLE and END.
REQ-031 SHALL change every output only on a clock edge (registered outputs, no combinational path from inputs).

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, set:
- fight_state=0 and option_state=0;
- p1_cur_hp=0 and p2_cur_hp=0;
- winner=0 and fight_done=0;
- tick counter and remaining damage to 0.
REQ-033 SHALL let reset asserted in any state, including mid-animation or mid-HP-reduction, abort the fight immediately to IDLE.

Verification
REQ-034 SHALL cover start, then enter, then key_right (option 2), key_down (option 4), enter:
- state sequence 1 -> 2 -> 3;
- after 30 ticks, state 6;
- 40 ticks later p2_cur_hp=160 and state 4.
REQ-035 SHALL cover a full round with skill 1 and default parameters: end state MENU, p1_cur_hp=185, p2_cur_hp=190, option_state=1.
REQ-036 SHALL cover the boundary of p2_cur_hp=25 with a skill 4 attack: HP reaches 0 after 25 ticks, then state 7, winner=1 and fight_done=1.
REQ-037 SHALL cover navigation at the grid edges: at option 1, key_left and key_up leave it at 1; at option 4, key_right and key_down leave it at 4; simultaneous key_up and key_left from option 4 give option 2.
REQ-038 SHALL cover rst_n=0 during HPRED_P2 at hp=170: the next cycle shows all outputs at their reset values, and a later start restores both HPs to 200.
REQ-039 SHALL cover start pulsed in MENU and tick pulsed in MENU: no change to any output.
